// File: rtl/fast_accel_hls_deadlock_report_ctrl_if.sv
// Bundle of detect-unit, token and report signals between the deadlock report
// controller (master) and the detect units / report consumer (slave).
interface fast_accel_hls_deadlock_report_ctrl_if #(
   parameter int PROC_NUM  = 4,
   parameter int PROC_ID_W = 2,
   parameter int CNT_W     = 8
);
   logic [PROC_NUM-1:0]  dl_detect_vec;
   logic [PROC_NUM-1:0]  token_return_vec;
   logic                 dl_report_ack;
   logic                 dl_detect_global;
   logic [PROC_NUM-1:0]  origin_vec;
   logic                 token_clear;
   logic                 dl_report_valid;
   logic [PROC_ID_W-1:0] dl_report_proc;
   logic                 dl_report_timeout;
   logic [CNT_W-1:0]     dl_report_cnt;

   modport master (
      input  dl_detect_vec, token_return_vec, dl_report_ack,
      output dl_detect_global, origin_vec, token_clear,
             dl_report_valid, dl_report_proc, dl_report_timeout, dl_report_cnt
   );

   modport slave (
      output dl_detect_vec, token_return_vec, dl_report_ack,
      input  dl_detect_global, origin_vec, token_clear,
             dl_report_valid, dl_report_proc, dl_report_timeout, dl_report_cnt
   );
endinterface

// File: rtl/fast_accel_hls_deadlock_report_ctrl.sv
// Deadlock report sequencer: confirms persistent detects, picks a process
// round-robin, fires its origin pulse, tracks token return and publishes one report.
module fast_accel_hls_deadlock_report_ctrl #(
   parameter int PROC_NUM       = 4,
   parameter int PROC_ID_W      = 2,
   parameter int CONFIRM_CYCLES = 8,
   parameter int TOKEN_TIMEOUT  = 64,
   parameter int CNT_W          = 8
) (
   input logic clock,
   input logic reset,
   fast_accel_hls_deadlock_report_ctrl_if.master bus
);
   localparam int CONF_W = $clog2(CONFIRM_CYCLES + 1);
   localparam int TO_W   = $clog2(TOKEN_TIMEOUT + 1);
   localparam logic [CONF_W-1:0]  CONF_LAST  = CONF_W'(CONFIRM_CYCLES - 1);
   localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TOKEN_TIMEOUT - 1);
   localparam logic [PROC_ID_W:0] PROC_NUM_W = (PROC_ID_W + 1)'(PROC_NUM);

   typedef enum logic [2:0] {
      S_IDLE, S_CONFIRM, S_SELECT, S_ORIGIN, S_WAIT, S_REPORT, S_CLEAR, S_DRAIN
   } state_t;

   state_t               state_reg, state_next;
   logic [CONF_W-1:0]    confirm_cnt_reg, confirm_cnt_next;
   logic [TO_W-1:0]      timeout_cnt_reg, timeout_cnt_next;
   logic [PROC_ID_W-1:0] rr_ptr_reg, rr_ptr_next;
   logic [PROC_ID_W-1:0] sel_reg, sel_next;
   logic                 timeout_flag_reg, timeout_flag_next;
   logic [CNT_W-1:0]     report_cnt_reg, report_cnt_next;

   logic                 global_reg, clear_reg, valid_reg, rep_timeout_reg;
   logic [PROC_NUM-1:0]  origin_reg, origin_next;
   logic [PROC_ID_W-1:0] rep_proc_reg;

   // Rotate the detect vector so bit 0 is the process at rr_ptr; the lowest set
   // bit of the rotated vector is then the next process in round-robin order.
   logic [2*PROC_NUM-1:0] detect_dbl;
   logic [PROC_NUM-1:0]   detect_rot;
   logic [PROC_ID_W-1:0]  pick_off, pick_idx, sel_inc;
   logic [PROC_ID_W:0]    pick_sum, sel_sum;
   logic                  pick_found;

   assign detect_dbl = {bus.dl_detect_vec, bus.dl_detect_vec};
   assign detect_rot = PROC_NUM'(detect_dbl >> rr_ptr_reg);

   always_comb begin
      pick_off   = '0;
      pick_found = 1'b0;
      for (int i = PROC_NUM - 1; i >= 0; i--) begin
         if (detect_rot[i]) begin
            pick_found = 1'b1;
            pick_off   = PROC_ID_W'(i);
         end
      end
   end

   assign pick_sum = {1'b0, rr_ptr_reg} + {1'b0, pick_off};
   assign pick_idx = (pick_sum >= PROC_NUM_W) ? PROC_ID_W'(pick_sum - PROC_NUM_W)
                                              : pick_sum[PROC_ID_W-1:0];
   assign sel_sum  = {1'b0, sel_reg} + 1'b1;
   assign sel_inc  = (sel_sum >= PROC_NUM_W) ? '0 : sel_sum[PROC_ID_W-1:0];

   always_comb begin
      state_next        = state_reg;
      confirm_cnt_next  = confirm_cnt_reg;
      timeout_cnt_next  = timeout_cnt_reg;
      rr_ptr_next       = rr_ptr_reg;
      sel_next          = sel_reg;
      timeout_flag_next = timeout_flag_reg;
      report_cnt_next   = report_cnt_reg;
      case (state_reg)
         S_IDLE: begin
            if (|bus.dl_detect_vec) begin
               confirm_cnt_next = CONF_W'(1);
               state_next       = (CONFIRM_CYCLES == 1) ? S_SELECT : S_CONFIRM;
            end
         end
         S_CONFIRM: begin
            if (!(|bus.dl_detect_vec)) begin
               confirm_cnt_next = '0;
               state_next       = S_IDLE;
            end else if (confirm_cnt_reg == CONF_LAST) begin
               confirm_cnt_next = '0;
               state_next       = S_SELECT;
            end else begin
               confirm_cnt_next = confirm_cnt_reg + 1'b1;
            end
         end
         S_SELECT: begin
            confirm_cnt_next = '0;
            if (pick_found) begin
               sel_next   = pick_idx;
               state_next = S_ORIGIN;
            end else begin
               state_next = S_IDLE;
            end
         end
         S_ORIGIN: begin
            timeout_cnt_next = '0;
            state_next       = S_WAIT;
         end
         S_WAIT: begin
            // Token return takes priority over a timeout in the same cycle.
            if (bus.token_return_vec[sel_reg]) begin
               timeout_flag_next = 1'b0;
               state_next        = S_REPORT;
            end else if (timeout_cnt_reg == TO_LAST) begin
               timeout_flag_next = 1'b1;
               state_next        = S_REPORT;
            end else begin
               timeout_cnt_next = timeout_cnt_reg + 1'b1;
            end
         end
         S_REPORT: begin
            if (bus.dl_report_ack) begin
               if (report_cnt_reg != '1) report_cnt_next = report_cnt_reg + 1'b1;
               rr_ptr_next = sel_inc;
               state_next  = S_CLEAR;
            end
         end
         S_CLEAR: state_next = S_DRAIN;
         S_DRAIN: state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   for (genvar gi = 0; gi < PROC_NUM; gi++) begin : g_origin
      assign origin_next[gi] = (state_next == S_ORIGIN) && (sel_next == PROC_ID_W'(gi));
   end

   // Outputs are flops loaded from the next state, so they line up with state_reg.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg        <= S_IDLE;
         confirm_cnt_reg  <= '0;
         timeout_cnt_reg  <= '0;
         rr_ptr_reg       <= '0;
         sel_reg          <= '0;
         timeout_flag_reg <= 1'b0;
         report_cnt_reg   <= '0;
         global_reg       <= 1'b0;
         origin_reg       <= '0;
         clear_reg        <= 1'b0;
         valid_reg        <= 1'b0;
         rep_proc_reg     <= '0;
         rep_timeout_reg  <= 1'b0;
      end else begin
         state_reg        <= state_next;
         confirm_cnt_reg  <= confirm_cnt_next;
         timeout_cnt_reg  <= timeout_cnt_next;
         rr_ptr_reg       <= rr_ptr_next;
         sel_reg          <= sel_next;
         timeout_flag_reg <= timeout_flag_next;
         report_cnt_reg   <= report_cnt_next;
         global_reg       <= (state_next == S_ORIGIN) || (state_next == S_WAIT) ||
                             (state_next == S_REPORT) || (state_next == S_CLEAR);
         origin_reg       <= origin_next;
         clear_reg        <= (state_next == S_CLEAR);
         valid_reg        <= (state_next == S_REPORT);
         rep_proc_reg     <= (state_next == S_REPORT) ? sel_next : '0;
         rep_timeout_reg  <= (state_next == S_REPORT) && timeout_flag_next;
      end
   end

   assign bus.dl_detect_global  = global_reg;
   assign bus.origin_vec        = origin_reg;
   assign bus.token_clear       = clear_reg;
   assign bus.dl_report_valid   = valid_reg;
   assign bus.dl_report_proc    = rep_proc_reg;
   assign bus.dl_report_timeout = rep_timeout_reg;
   assign bus.dl_report_cnt     = report_cnt_reg;
endmodule

// File: tb/tb_fast_accel_hls_deadlock_report_ctrl.sv
// Scoreboard bench for the deadlock report controller: expected reports are queued
// as each deadlock is staged and popped when dl_report_valid appears.
module tb_fast_accel_hls_deadlock_report_ctrl;
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   fast_accel_hls_deadlock_report_ctrl_if #(.PROC_NUM(4), .PROC_ID_W(2), .CNT_W(8)) bus ();

   fast_accel_hls_deadlock_report_ctrl #(
      .PROC_NUM(4), .PROC_ID_W(2), .CONFIRM_CYCLES(8), .TOKEN_TIMEOUT(64), .CNT_W(8)
   ) u_dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   typedef struct {
      logic [1:0] proc;
      logic       timeout;
   } rep_t;

   rep_t       exp_q[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_cnt = 8'd0;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.dl_detect_vec    = '0;
      bus.token_return_vec = '0;
      bus.dl_report_ack    = 1'b0;
      repeat (3) tick();
      reset   = 1'b0;
      exp_cnt = 8'd0;
      exp_q.delete();
   endtask

   task automatic check_quiet(input string name);
      checks++;
      if (bus.dl_detect_global !== 1'b0 || bus.origin_vec !== 4'b0 || bus.token_clear !== 1'b0 ||
          bus.dl_report_valid !== 1'b0 || bus.dl_report_proc !== 2'd0 ||
          bus.dl_report_timeout !== 1'b0 || bus.dl_report_cnt !== exp_cnt) begin
         errors++;
         $display("FAIL %s: got glb=%b org=%b clr=%b vld=%b proc=%0d to=%b cnt=%0d, want all 0 cnt=%0d",
                  name, bus.dl_detect_global, bus.origin_vec, bus.token_clear, bus.dl_report_valid,
                  bus.dl_report_proc, bus.dl_report_timeout, bus.dl_report_cnt, exp_cnt);
      end
   endtask

   // Caller has just raised dl_detect_vec from IDLE; origin must show after exactly 9 edges.
   task automatic wait_origin_exact(input logic [3:0] want);
      repeat (8) tick();
      checks++;
      if (bus.origin_vec !== 4'b0 || bus.dl_detect_global !== 1'b0) begin
         errors++;
         $display("FAIL origin_early: got org=%b glb=%b, want 0000/0", bus.origin_vec, bus.dl_detect_global);
      end
      tick();
      checks++;
      if (bus.origin_vec !== want || bus.dl_detect_global !== 1'b1) begin
         errors++;
         $display("FAIL origin_time: got org=%b glb=%b, want %b/1", bus.origin_vec, bus.dl_detect_global, want);
      end
      tick();
      checks++;
      if (bus.origin_vec !== 4'b0 || bus.dl_detect_global !== 1'b1) begin
         errors++;
         $display("FAIL origin_pulse: got org=%b glb=%b, want 0000/1", bus.origin_vec, bus.dl_detect_global);
      end
   endtask

   task automatic wait_origin(output logic [3:0] seen);
      int n = 0;
      while (bus.origin_vec === 4'b0 && n < 100) begin
         tick();
         n++;
      end
      seen = bus.origin_vec;
      checks++;
      if (seen === 4'b0) begin
         errors++;
         $display("FAIL origin_wait: got no origin within 100 cycles, want a pulse");
      end
   endtask

   task automatic collect_report(input int hold, input bit wiggle);
      rep_t e;
      int   n = 0;
      while (bus.dl_report_valid !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (bus.dl_report_valid !== 1'b1) begin
         errors++;
         $display("FAIL report_wait: got valid=%b after 200 cycles, want 1", bus.dl_report_valid);
         return;
      end
      bus.token_return_vec = '0;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL report_unexpected: got proc=%0d with empty scoreboard, want none", bus.dl_report_proc);
         return;
      end
      e = exp_q.pop_front();
      if (bus.dl_report_proc !== e.proc || bus.dl_report_timeout !== e.timeout) begin
         errors++;
         $display("FAIL report_data: got proc=%0d to=%b, want proc=%0d to=%b",
                  bus.dl_report_proc, bus.dl_report_timeout, e.proc, e.timeout);
      end
      for (int i = 0; i < hold; i++) begin
         if (wiggle) bus.dl_detect_vec = 4'($urandom);
         tick();
         checks++;
         if (bus.dl_report_valid !== 1'b1 || bus.dl_report_proc !== e.proc ||
             bus.dl_report_timeout !== e.timeout || bus.origin_vec !== 4'b0) begin
            errors++;
            $display("FAIL report_stable: got vld=%b proc=%0d to=%b org=%b, want 1/%0d/%b/0000",
                     bus.dl_report_valid, bus.dl_report_proc, bus.dl_report_timeout,
                     bus.origin_vec, e.proc, e.timeout);
         end
      end
      bus.dl_report_ack = 1'b1;
      tick();
      bus.dl_report_ack = 1'b0;
      if (exp_cnt != 8'hff) exp_cnt++;
      checks++;
      if (bus.token_clear !== 1'b1 || bus.dl_detect_global !== 1'b1 ||
          bus.dl_report_valid !== 1'b0 || bus.dl_report_cnt !== exp_cnt) begin
         errors++;
         $display("FAIL clear: got clr=%b glb=%b vld=%b cnt=%0d, want 1/1/0/%0d",
                  bus.token_clear, bus.dl_detect_global, bus.dl_report_valid, bus.dl_report_cnt, exp_cnt);
      end
      tick();
      checks++;
      if (bus.token_clear !== 1'b0 || bus.dl_detect_global !== 1'b0) begin
         errors++;
         $display("FAIL drain: got clr=%b glb=%b, want 0/0", bus.token_clear, bus.dl_detect_global);
      end
      $display("report proc=%0d timeout=%b cnt=%0d", e.proc, e.timeout, bus.dl_report_cnt);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.dl_detect_vec    = 4'b1111;
      bus.token_return_vec = 4'b1111;
      bus.dl_report_ack    = 1'b1;
      repeat (2) tick();
      exp_cnt = 8'd0;
      check_quiet("reset_state");
      do_reset();
      check_quiet("after_reset");
   endtask

   task automatic test_single();
      do_reset();
      bus.dl_detect_vec = 4'b0100;
      wait_origin_exact(4'b0100);
      repeat (4) tick();
      exp_q.push_back('{proc: 2'd2, timeout: 1'b0});
      bus.token_return_vec = 4'b0100;
      collect_report(0, 1'b0);
      bus.dl_detect_vec = 4'b0;
   endtask

   task automatic test_glitch();
      logic seen = 1'b0;
      repeat (2) tick();
      bus.dl_detect_vec = 4'b0001;
      for (int i = 0; i < 7; i++) begin
         tick();
         seen = seen | bus.dl_detect_global | (|bus.origin_vec);
      end
      bus.dl_detect_vec = 4'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         seen = seen | bus.dl_detect_global | (|bus.origin_vec);
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL glitch: got origin/global activity=%b, want 0", seen);
      end
   endtask

   task automatic run_one(input logic [3:0] vec, input logic [1:0] want_proc);
      logic [3:0] seen;
      logic [3:0] onehot;
      onehot = 4'(1 << want_proc);
      bus.dl_detect_vec = vec;
      exp_q.push_back('{proc: want_proc, timeout: 1'b0});
      wait_origin(seen);
      checks++;
      if (seen !== onehot) begin
         errors++;
         $display("FAIL origin_sel: got %b, want %b", seen, onehot);
      end
      bus.token_return_vec = seen;
      collect_report(0, 1'b0);
   endtask

   task automatic test_round_robin();
      logic [1:0] order[4] = '{2'd1, 2'd3, 2'd1, 2'd3};
      do_reset();
      for (int i = 0; i < 4; i++) run_one(4'b1010, order[i]);
      run_one(4'b1001, 2'd0);
      bus.dl_detect_vec = 4'b0;
   endtask

   task automatic test_timeout();
      logic [3:0] seen;
      do_reset();
      bus.dl_detect_vec = 4'b0001;
      for (int k = 0; k < 2; k++) begin
         wait_origin(seen);
         tick();
         repeat (63) tick();
         checks++;
         if (bus.dl_report_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: got valid=%b after 63 wait cycles, want 0", bus.dl_report_valid);
         end
         if (k == 1) bus.token_return_vec = 4'b0001;
         exp_q.push_back('{proc: 2'd0, timeout: (k == 0)});
         tick();
         checks++;
         if (bus.dl_report_valid !== 1'b1) begin
            errors++;
            $display("FAIL timeout_edge: got valid=%b after 64 wait cycles, want 1", bus.dl_report_valid);
         end
         collect_report(0, 1'b0);
      end
      bus.dl_detect_vec = 4'b0;
   endtask

   task automatic test_backpressure();
      logic [3:0] seen;
      do_reset();
      bus.dl_detect_vec = 4'b0100;
      exp_q.push_back('{proc: 2'd2, timeout: 1'b0});
      wait_origin(seen);
      bus.token_return_vec = seen;
      collect_report(20, 1'b1);
      bus.dl_detect_vec = 4'b0;
   endtask

   task automatic test_saturation();
      logic [1:0] p;
      do_reset();
      for (int i = 0; i < 256; i++) begin
         p = 2'($urandom_range(0, 3));
         run_one(4'(1 << p), p);
         bus.dl_detect_vec = 4'b0;
      end
      checks++;
      if (bus.dl_report_cnt !== 8'hff) begin
         errors++;
         $display("FAIL cnt_saturate: got %0d, want 255", bus.dl_report_cnt);
      end
   endtask

   task automatic test_reset_midflight();
      logic [3:0] seen;
      int         n = 0;
      do_reset();
      bus.dl_detect_vec = 4'b0100;
      wait_origin(seen);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_cnt = 8'd0;
      exp_q.delete();
      check_quiet("reset_in_wait");
      wait_origin_exact(4'b0100);
      exp_q.push_back('{proc: 2'd2, timeout: 1'b0});
      bus.token_return_vec = 4'b0100;
      collect_report(0, 1'b0);
      wait_origin(seen);
      bus.token_return_vec = seen;
      while (bus.dl_report_valid !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      reset = 1'b1;
      bus.token_return_vec = 4'b0;
      bus.dl_detect_vec    = 4'b0010;
      tick();
      reset = 1'b0;
      exp_cnt = 8'd0;
      exp_q.delete();
      check_quiet("reset_in_report");
      wait_origin_exact(4'b0010);
      exp_q.push_back('{proc: 2'd1, timeout: 1'b0});
      bus.token_return_vec = 4'b0010;
      collect_report(0, 1'b0);
      bus.dl_detect_vec = 4'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_glitch();
      test_round_robin();
      test_timeout();
      test_backpressure();
      test_saturation();
      test_reset_midflight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
